// File: rtl/alu_vec_pkg.sv
// Shared types and helpers for the vector-ALU result collector.
package alu_vec_pkg;

  // Collector sequencing: waiting for a snapshot, or streaming one lane per beat.
  typedef enum logic {
    IDLE,
    STREAM
  } collector_state_t;

  // Bit positions inside the 3-bit {greater, equal, less} flag group.
  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;
  localparam int FLAG_W  = 3;

  // A well-formed compare result has exactly one of greater/equal/less set.
  function automatic logic is_onehot3(input logic [FLAG_W-1:0] flags);
    return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  endfunction

endpackage

// File: rtl/alu_vec_result_collector.sv
// Snapshots the parallel per-lane ALU results and compare flags on a capture
// pulse, then serialises them lane 0 first over a valid/ready stream.
module alu_vec_result_collector
  import alu_vec_pkg::*;
#(
  parameter  int ALUs_num    = 4,
  parameter  int INPUT_WIDTH = 8,
  localparam int LANE_W      = (ALUs_num > 1) ? $clog2(ALUs_num) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       capture,
  input  logic [2*INPUT_WIDTH-1:0]   result_in [ALUs_num],
  input  logic [ALUs_num-1:0]        a_greater_in,
  input  logic [ALUs_num-1:0]        a_equal_in,
  input  logic [ALUs_num-1:0]        a_less_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANE_W-1:0]          out_lane,
  output logic [2*INPUT_WIDTH-1:0]   out_result,
  output logic [FLAG_W-1:0]          out_flags,
  output logic                       out_flag_err,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       capture_drop
);

  localparam int                RES_W     = 2 * INPUT_WIDTH;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(ALUs_num - 1);

  collector_state_t    state;
  logic [LANE_W-1:0]   lane;
  logic [RES_W-1:0]    snap_result [ALUs_num];
  logic [ALUs_num-1:0] snap_gt;
  logic [ALUs_num-1:0] snap_eq;
  logic [ALUs_num-1:0] snap_lt;
  logic                done_q;
  logic                drop_q;

  logic                streaming;
  logic                at_last_lane;
  logic                handshake;
  logic                final_beat;
  logic                take_snapshot;
  logic [FLAG_W-1:0]   lane_flags;

  assign streaming    = (state == STREAM);
  assign at_last_lane = (lane == LAST_LANE);
  assign handshake    = streaming && out_ready;
  assign final_beat   = handshake && at_last_lane;

  // A new snapshot is taken from idle, or on the final beat so streams chain without a bubble.
  assign take_snapshot = capture && ((state == IDLE) || final_beat);

  // Gather the current lane's compare flags into the {greater, equal, less} group.
  always_comb begin
    lane_flags          = '0;
    lane_flags[FLAG_GT] = snap_gt[lane];
    lane_flags[FLAG_EQ] = snap_eq[lane];
    lane_flags[FLAG_LT] = snap_lt[lane];
  end

  // Beat outputs come straight from the snapshot and read as zero whenever idle.
  assign out_valid    = streaming;
  assign busy         = streaming;
  assign out_lane     = streaming ? lane : '0;
  assign out_result   = streaming ? snap_result[lane] : '0;
  assign out_flags    = streaming ? lane_flags : '0;
  assign out_flag_err = streaming && !is_onehot3(lane_flags);
  assign out_last     = streaming && at_last_lane;
  assign done         = done_q;
  assign capture_drop = drop_q;

  // Snapshot registers only load when a capture is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALUs_num; i++) begin
        snap_result[i] <= '0;
      end
      snap_gt <= '0;
      snap_eq <= '0;
      snap_lt <= '0;
    end else if (take_snapshot) begin
      for (int i = 0; i < ALUs_num; i++) begin
        snap_result[i] <= result_in[i];
      end
      snap_gt <= a_greater_in;
      snap_eq <= a_equal_in;
      snap_lt <= a_less_in;
    end
  end

  // Sequencer: walks the lane counter on each handshake and issues the done/drop pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lane   <= '0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            lane  <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (at_last_lane) begin
              done_q <= 1'b1;
              lane   <= '0;
              if (!capture) begin
                state <= IDLE;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
          if (capture && !final_beat) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          lane  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vec_result_collector.sv
// Randomised and directed bench for the result collector with a queue-based scoreboard.
module tb_alu_vec_result_collector;

  localparam int ALUS = 4;
  localparam int IW   = 8;
  localparam int RW   = 2 * IW;
  localparam int LW   = 2;

  logic            clk;
  logic            rst_n;
  logic            capture;
  logic [RW-1:0]   result_in [ALUS];
  logic [ALUS-1:0] a_greater_in;
  logic [ALUS-1:0] a_equal_in;
  logic [ALUS-1:0] a_less_in;
  logic            out_valid;
  logic            out_ready;
  logic [LW-1:0]   out_lane;
  logic [RW-1:0]   out_result;
  logic [2:0]      out_flags;
  logic            out_flag_err;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            capture_drop;

  alu_vec_result_collector #(.ALUs_num(ALUS), .INPUT_WIDTH(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (capture),
    .result_in    (result_in),
    .a_greater_in (a_greater_in),
    .a_equal_in   (a_equal_in),
    .a_less_in    (a_less_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane     (out_lane),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_flag_err (out_flag_err),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .capture_drop (capture_drop)
  );

  typedef struct {
    int         lane;
    logic [RW-1:0] result;
    logic [2:0] flags;
    logic       err;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    checks    = 0;
  int    errors    = 0;
  int    remaining = 0;
  logic  exp_done  = 1'b0;
  logic  exp_drop  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic cap, input logic rdy);
    @(posedge clk);
    #1;
    capture   = cap;
    out_ready = rdy;
  endtask

  task automatic setLane(input int i, input logic [RW-1:0] res, input logic g, input logic e, input logic l);
    result_in[i]    = res;
    a_greater_in[i] = g;
    a_equal_in[i]   = e;
    a_less_in[i]    = l;
  endtask

  task automatic setAllLanes(input logic [RW-1:0] res);
    for (int i = 0; i < ALUS; i++) setLane(i, res, 1'b0, 1'b1, 1'b0);
  endtask

  // Reference model: a snapshot is a list of ALUS beats; tracks how many are still owed.
  always @(negedge clk) begin : model
    logic  hs;
    logic  accept;
    beat_t b;
    if (!rst_n) begin
      exp_q.delete();
      remaining = 0;
      exp_done  = 1'b0;
      exp_drop  = 1'b0;
    end else begin
      checkOutput("valid", 32'(out_valid), 32'(remaining > 0));
      checkOutput("busy", 32'(busy), 32'(remaining > 0));
      checkOutput("done", 32'(done), 32'(exp_done));
      checkOutput("capture_drop", 32'(capture_drop), 32'(exp_drop));
      if (remaining == 0)
        checkOutput("idle_outputs_zero",
                    32'({out_lane, out_result, out_flags, out_flag_err, out_last}), 32'(0));
      hs       = (remaining > 0) && out_ready;
      accept   = capture && ((remaining == 0) || ((remaining == 1) && out_ready));
      exp_done = hs && (remaining == 1);
      exp_drop = capture && !accept;
      if (hs) remaining--;
      if (accept) begin
        for (int i = 0; i < ALUS; i++) begin
          b.lane   = i;
          b.result = result_in[i];
          b.flags  = {a_greater_in[i], a_equal_in[i], a_less_in[i]};
          b.err    = (int'(a_greater_in[i]) + int'(a_equal_in[i]) + int'(a_less_in[i])) != 1;
          b.last   = (i == ALUS - 1);
          exp_q.push_back(b);
        end
        remaining = ALUS;
      end
    end
  end

  // Monitor: every cycle a beat is presented it must match the queue head; pop on handshake.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat actual=lane%0d expected=none at %0t", out_lane, $time);
      end else begin
        e = exp_q[0];
        checkOutput("beat_lane", 32'(out_lane), 32'(e.lane));
        checkOutput("beat_result", 32'(out_result), 32'(e.result));
        checkOutput("beat_flags", 32'(out_flags), 32'(e.flags));
        checkOutput("beat_flag_err", 32'(out_flag_err), 32'(e.err));
        checkOutput("beat_last", 32'(out_last), 32'(e.last));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    capture   = 1'b0;
    out_ready = 1'b0;
    setAllLanes('0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done_drop", 32'({done, capture_drop}), 32'(0));
    checkOutput("reset_beat", 32'({out_lane, out_result, out_flags, out_flag_err, out_last}), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] basic capture and stream");
    setLane(0, 16'h0010, 1'b1, 1'b0, 1'b0);
    setLane(1, 16'h00FF, 1'b0, 1'b1, 1'b0);
    setLane(2, 16'h1234, 1'b0, 1'b0, 1'b1);
    setLane(3, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b1);

    $display("[TB] backpressure at lane 1");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1);

    $display("[TB] dropped capture at lane 2");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    setAllLanes(16'hAAAA);
    applyStimulus(1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b1);

    $display("[TB] back-to-back capture on final beat");
    setAllLanes(16'h1111);
    applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    setAllLanes(16'hBEEF);
    applyStimulus(1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b1);

    $display("[TB] malformed compare flags");
    setLane(0, 16'h0101, 1'b1, 1'b0, 1'b0);
    setLane(1, 16'h0202, 1'b1, 1'b1, 1'b0);
    setLane(2, 16'h0303, 1'b0, 1'b0, 1'b1);
    setLane(3, 16'h0404, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b1);

    $display("[TB] reset in the middle of a stream");
    setAllLanes(16'h5A5A);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'(0));
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    checkOutput("midrst_done", 32'(done), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    setAllLanes(16'hC0DE);
    applyStimulus(1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b1);

    $display("[TB] randomised traffic");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < ALUS; i++) begin
        logic [2:0] f;
        f = 3'($urandom_range(0, 7));
        setLane(i, RW'($urandom), f[2], f[1], f[0]);
      end
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    repeat (10) applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_vec_result_collector.md
Name: alu_vec_result_collector

Overview:
- Consumer side of the vector-ALU output interface.
- On a capture pulse, snapshots the parallel per-lane results and compare flags, then streams them out one lane per beat over a valid/ready interface (lane 0 first).
- Sits between the vector ALU array and any narrow downstream consumer (UART/bus bridge, scoreboard FIFO).
- Per beat, flags any lane whose compare flags are not one-hot.

Parameters:
- ALUs_num, 4, number of ALU lanes captured per snapshot (>=1).
- INPUT_WIDTH, 8, ALU operand width; results are 2*INPUT_WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- capture  input  1  single-cycle request to snapshot all lane inputs.
- result_in  input  [2*INPUT_WIDTH-1:0] x ALUs_num (unpacked array)  per-lane ALU results.
- a_greater_in  input  ALUs_num  per-lane A>B flag.
- a_equal_in  input  ALUs_num  per-lane A==B flag.
- a_less_in  input  ALUs_num  per-lane A<B flag.
- out_valid  output  1  beat available.
- out_ready  input  1  downstream accepts the beat.
- out_lane  output  LANE_W = max(1, $clog2(ALUs_num))  lane index of the current beat.
- out_result  output  2*INPUT_WIDTH  result of the current lane.
- out_flags  output  3  {greater, equal, less} of the current lane.
- out_flag_err  output  1  current lane flags are not exactly one-hot.
- out_last  output  1  current beat is lane ALUs_num-1.
- busy  output  1  a snapshot is being streamed.
- done  output  1  one-cycle pulse after the last beat handshakes.
- capture_drop  output  1  one-cycle pulse when a capture was ignored.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE. The lane counter and all snapshot registers clear. Every output reads 0, including out_valid, busy, done, capture_drop, out_lane, out_result, out_flags, out_flag_err and out_last.
- Reset mid-stream aborts the transfer immediately. out_valid drops without waiting for a clock and no done pulse is issued.
- FSM has two states: IDLE and STREAM.
- IDLE, capture=1:
  - Register result_in and the three flag vectors into the snapshot at that edge.
  - Set lane=0 and go to STREAM.
  - out_valid is asserted the next cycle, giving one cycle capture-to-valid latency.
- IDLE, capture=0: hold state. All outputs stay 0.
- STREAM:
  - out_valid=1 and busy=1.
  - out_result, out_flags, out_flag_err and out_last are driven combinationally from the snapshot, indexed by lane. They are stable while out_valid=1 and out_ready=0.
- Handshake: a beat transfers on a rising edge when out_valid and out_ready are both 1. A beat is never dropped or repeated. out_ready may toggle freely.
- Handshake with lane < ALUs_num-1: lane increments.
- Handshake with lane == ALUs_num-1:
  - done pulses for 1 cycle.
  - With capture=0 in the same cycle: go to IDLE.
  - With capture=1 in the same cycle: take a new snapshot, set lane=0 and stay in STREAM. This gives back-to-back operation with no bubble.
- capture in STREAM, other than on the final-beat handshake: ignored. The snapshot is unchanged and capture_drop pulses 1 cycle later.
- out_flag_err = NOT exactly one of {greater, equal, less} set. It is informational only and does not stall the stream.
- ALUs_num=1: every beat has out_last=1 and out_lane=0.
- Lane counter never exceeds ALUs_num-1, so there is no wrap past the last lane.

Decomposition:
- Package alu_vec_pkg holds:
  - typedef enum logic {IDLE, STREAM} collector_state_t.
  - localparams FLAG_GT=2, FLAG_EQ=1, FLAG_LT=0, FLAG_W=3.
  - Function is_onehot3().
- No sub-module is needed. The lane mux and the one-hot check are inline.

Test Plan:
- Reset and capture: hold rst_n=0 for 3 cycles, release, pulse capture with lanes {0x0010, 0x00FF, 0x1234, 0x0000} and flags gt/eq/lt/eq, out_ready=1 throughout.
  - Required: 4 consecutive beats starting the cycle after capture, with lanes 0..3 and matching data.
  - Required: out_last only on lane 3, done 1 cycle after the lane-3 handshake, out_flag_err=0 on all beats.
- Backpressure: out_ready=0 for 5 cycles at lane 1, then 1.
  - Required: lane 1 data (0x00FF) held stable for all 5 cycles, lane 2 follows, no duplicate or missing beats.
- Dropped capture: pulse capture at lane 2 with new data (all lanes 0xAAAA).
  - Required: capture_drop pulses once and lanes 2..3 still carry the original snapshot.
- Back-to-back: capture coincident with the lane-3 handshake, new data 0xBEEF on all lanes.
  - Required: done=1 that cycle, busy stays 1, and the next beat is lane 0 = 0xBEEF with no idle cycle.
- Flag error: lane 1 flags gt=1, eq=1; lane 3 flags all 0.
  - Required: out_flag_err=1 exactly on the lane-1 and lane-3 beats.
- Mid-stream reset: assert rst_n=0 asynchronously mid-cycle at lane 2.
  - Required: out_valid/busy go 0 before the next edge with no done pulse, and a subsequent capture restarts at lane 0.
